if_fetch_stage: RTL and testbench

Instruction-fetch stage that owns the program counter and feeds the IF/ID pipeline register. It drives a request/acknowledge instruction-memory port, advances PC by 4 per consumed instruction, honours the hazard unit's stall (PCWrite), and redirects to a branch target when the MEM-stage taken-branch signal (PCSrc) fires. When it has no valid instruction, or is squashing one, it presents a NOP (32'h0) so IF/ID always captures a legal word.

---
 rtl/if_fetch_stage_if.sv | 23 ++
 rtl/if_fetch_stage.sv | 91 +++++++++
 tb/tb_if_fetch_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory req/ack port plus the IF/ID-facing signals.
// master = fetch stage, slave = memory, hazard unit and pipeline environment.
interface if_fetch_stage_if;
  logic        PCWrite;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instr_out;
  logic [31:0] PC_added_out;

  modport master (
    input  PCWrite, PCSrc, branch_target, imem_rdata, imem_ack,
    output imem_req, imem_addr, Instr_out, PC_added_out
  );

  modport slave (
    output PCWrite, PCSrc, branch_target, imem_rdata, imem_ack,
    input  imem_req, imem_addr, Instr_out, PC_added_out
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns pc, presents the acked word (or NOP) to IF/ID combinationally, 0 extra cycles.
// A word presented under PCWrite=0 is held with no new request; a redirect during an outstanding request waits for its ack.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_saved_target;
  logic [31:0] r_buf_instr;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_word_vld;
  logic [31:0] w_word;

  assign w_target   = bus.branch_target & ~32'h3;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_word_vld = 1'b0;
    w_word     = bus.imem_rdata;
    if (r_state == S_FETCH) begin
      w_word_vld = bus.imem_ack;
    end else if (r_state == S_HOLD) begin
      w_word_vld = 1'b1;
      w_word     = r_buf_instr;
    end
  end

  // A taken branch squashes whatever word is on offer this cycle.
  assign bus.Instr_out    = (!rst && w_word_vld && !bus.PCSrc) ? w_word : 32'h0;
  assign bus.imem_req     = !rst && (r_state != S_HOLD);
  assign bus.imem_addr    = r_pc;
  assign bus.PC_added_out = w_pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_PC;
      r_saved_target <= 32'h0;
      r_buf_instr    <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.PCSrc) begin
            if (bus.imem_ack) begin
              r_pc <= w_target;
            end else begin
              r_saved_target <= w_target;
              r_state        <= S_DROP;
            end
          end else if (bus.imem_ack) begin
            if (bus.PCWrite) begin
              r_pc <= w_pc_plus4;
            end else begin
              r_buf_instr <= bus.imem_rdata;
              r_state     <= S_HOLD;
            end
          end
        end
        S_DROP: begin
          // The in-flight request cannot be withdrawn; its word is dropped on arrival.
          if (bus.imem_ack) begin
            r_pc    <= bus.PCSrc ? w_target : r_saved_target;
            r_state <= S_FETCH;
          end else if (bus.PCSrc) begin
            r_saved_target <= w_target;
          end
        end
        S_HOLD: begin
          if (bus.PCSrc) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (bus.PCWrite) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: one DUT at RESET_PC=0, one at RESET_PC=FFFF_FFFC for wrap.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  if_fetch_stage_if bus_a ();
  if_fetch_stage_if bus_b ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic ack, input logic pcw, input logic src,
                         input logic [31:0] tgt, input logic [31:0] rdata);
    bus_a.imem_ack      = ack;
    bus_a.PCWrite       = pcw;
    bus_a.PCSrc         = src;
    bus_a.branch_target = tgt;
    bus_a.imem_rdata    = rdata;
    #1;
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus_b.imem_ack      = 1'b0;
    bus_b.PCWrite       = 1'b0;
    bus_b.PCSrc         = 1'b0;
    bus_b.branch_target = 32'h0;
    bus_b.imem_rdata    = 32'h0;
    cyc();

    // Reset state
    chk("rst_req", {31'b0, bus_a.imem_req}, 32'h0);
    chk("rst_instr", bus_a.Instr_out, 32'h0);
    chk("rst_pcadd", bus_a.PC_added_out, 32'h4);

    // Zero-wait streaming 0,4,8,12
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 32'h0, word(32'(4 * i)));
      chk("zw_req", {31'b0, bus_a.imem_req}, 32'h1);
      chk("zw_addr", bus_a.imem_addr, 32'(4 * i));
      chk("zw_instr", bus_a.Instr_out, word(32'(4 * i)));
      chk("zw_pcadd", bus_a.PC_added_out, 32'(4 * i + 4));
      cyc();
    end

    // 3-cycle latency at 0x10
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
      chk("lat_addr", bus_a.imem_addr, 32'h10);
      chk("lat_bubble", bus_a.Instr_out, 32'h0);
      cyc();
    end
    drive_a(1'b1, 1'b1, 1'b0, 32'h0, word(32'h10));
    chk("lat_addr3", bus_a.imem_addr, 32'h10);
    chk("lat_instr", bus_a.Instr_out, word(32'h10));
    cyc();

    // Zero-wait 0x14..0x1C to reach 0x20
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 32'h0, word(32'(20 + 4 * i)));
      chk("zw2_addr", bus_a.imem_addr, 32'(20 + 4 * i));
      cyc();
    end

    // Stall at 0x20: ack with PCWrite=0, one more stalled cycle, then release
    drive_a(1'b1, 1'b0, 1'b0, 32'h0, word(32'h20));
    chk("st_addr", bus_a.imem_addr, 32'h20);
    chk("st_instr0", bus_a.Instr_out, word(32'h20));
    chk("st_pcadd0", bus_a.PC_added_out, 32'h24);
    cyc();
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    chk("st_req1", {31'b0, bus_a.imem_req}, 32'h0);
    chk("st_instr1", bus_a.Instr_out, word(32'h20));
    chk("st_pcadd1", bus_a.PC_added_out, 32'h24);
    cyc();
    drive_a(1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
    chk("st_req2", {31'b0, bus_a.imem_req}, 32'h0);
    chk("st_instr2", bus_a.Instr_out, word(32'h20));
    cyc();
    chk("st_next_req", {31'b0, bus_a.imem_req}, 32'h1);
    chk("st_next_addr", bus_a.imem_addr, 32'h24);

    // Zero-wait 0x24..0x3C to reach 0x40
    for (int i = 0; i < 7; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 32'h0, word(32'(36 + 4 * i)));
      chk("zw3_instr", bus_a.Instr_out, word(32'(36 + 4 * i)));
      cyc();
    end

    // Branch while request to 0x40 outstanding -> DROP
    drive_a(1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0);
    chk("dr_addr0", bus_a.imem_addr, 32'h40);
    chk("dr_instr0", bus_a.Instr_out, 32'h0);
    cyc();
    drive_a(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("dr_req1", {31'b0, bus_a.imem_req}, 32'h1);
    chk("dr_addr1", bus_a.imem_addr, 32'h40);
    chk("dr_instr1", bus_a.Instr_out, 32'h0);
    cyc();
    drive_a(1'b1, 1'b1, 1'b0, 32'h0, word(32'h40));
    chk("dr_ack_instr", bus_a.Instr_out, 32'h0);
    cyc();
    drive_a(1'b1, 1'b0, 1'b0, 32'h0, word(32'h100));
    chk("dr_tgt_addr", bus_a.imem_addr, 32'h100);
    chk("dr_tgt_instr", bus_a.Instr_out, word(32'h100));
    cyc();

    // Now in HOLD with word(0x100); branch to 0x200 squashes it
    drive_a(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0);
    chk("hb_req", {31'b0, bus_a.imem_req}, 32'h0);
    chk("hb_instr", bus_a.Instr_out, 32'h0);
    cyc();
    drive_a(1'b1, 1'b1, 1'b0, 32'h0, word(32'h200));
    chk("hb_addr", bus_a.imem_addr, 32'h200);
    chk("hb_instr2", bus_a.Instr_out, word(32'h200));
    cyc();

    // Branch in FETCH with ack: word squashed, next fetch at target
    drive_a(1'b1, 1'b1, 1'b1, 32'h0000_0082, word(32'h204));
    chk("fb_addr", bus_a.imem_addr, 32'h204);
    chk("fb_instr", bus_a.Instr_out, 32'h0);
    cyc();

    // Reset mid-wait at 0x80
    drive_a(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("rw_addr", bus_a.imem_addr, 32'h80);
    cyc();
    rst_a = 1'b1;
    #1;
    chk("rw_req", {31'b0, bus_a.imem_req}, 32'h0);
    chk("rw_instr", bus_a.Instr_out, 32'h0);
    chk("rw_pcadd", bus_a.PC_added_out, 32'h84);
    cyc();
    rst_a = 1'b0;
    #1;
    chk("rw_after_req", {31'b0, bus_a.imem_req}, 32'h1);
    chk("rw_after_addr", bus_a.imem_addr, 32'h0);

    // Wrap-around from RESET_PC=FFFF_FFFC
    chk("wr_rst_pcadd", bus_b.PC_added_out, 32'h0);
    chk("wr_rst_req", {31'b0, bus_b.imem_req}, 32'h0);
    rst_b = 1'b0;
    bus_b.imem_ack   = 1'b1;
    bus_b.PCWrite    = 1'b1;
    bus_b.imem_rdata = word(32'hFFFF_FFFC);
    #1;
    chk("wr_addr0", bus_b.imem_addr, 32'hFFFF_FFFC);
    chk("wr_pcadd0", bus_b.PC_added_out, 32'h0);
    chk("wr_instr0", bus_b.Instr_out, word(32'hFFFF_FFFC));
    cyc();
    bus_b.imem_rdata = word(32'h0);
    #1;
    chk("wr_addr1", bus_b.imem_addr, 32'h0);
    chk("wr_pcadd1", bus_b.PC_added_out, 32'h4);
    chk("wr_instr1", bus_b.Instr_out, word(32'h0));
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
